// File: rtl/game_round_ctrl.sv
// game_round_ctrl: attract -> countdown -> fight -> round-over -> match-over sequencer for footies.
// Optional fight pause is built in when GAME_PAUSE_EN is defined.
module game_round_ctrl #(
    parameter int unsigned FRAMES_PER_SEC = 60,
    parameter int unsigned COUNTDOWN_SECS = 3,
    parameter int unsigned ROUND_TIME     = 60,
    parameter int unsigned WIN_ROUNDS     = 2,
    parameter int unsigned OVER_FRAMES    = 120
) (
    input  logic       clk_pix,
    input  logic       sim_rst_n,
    input  logic       frame_tick,
    input  logic       btn_fire,
    input  logic       hit_p1,
    input  logic       hit_p2,
    output logic [2:0] game_state,
    output logic       play_en,
    output logic [1:0] countdown,
    output logic [6:0] round_timer,
    output logic [1:0] p1_rounds,
    output logic [1:0] p2_rounds,
    output logic [1:0] round_winner,
    output logic       new_round,
    output logic       paused
);
    localparam int unsigned FW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_COUNTDOWN  = 3'd1,
        S_FIGHT      = 3'd2,
        S_ROUND_OVER = 3'd3,
        S_MATCH_OVER = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]    over_cnt_q, over_cnt_d;
    logic          fire_q, armed_q;
    logic          fire_rise, sec_tick, round_end, pause_q;
    logic          play_en_d, new_round_d;
    logic [1:0]    countdown_d, p1_d, p2_d, winner_d;
    logic [6:0]    timer_d;
`ifdef GAME_PAUSE_EN
    logic          pause_d;
`endif

    // armed_q masks the first cycle after reset so a held button gives no edge
    assign fire_rise  = btn_fire & ~fire_q & armed_q;
    assign sec_tick   = frame_tick && (frame_cnt_q == FW'(FRAMES_PER_SEC - 1));
    assign game_state = state_q;
    assign paused     = pause_q;

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        over_cnt_d  = over_cnt_q;
        play_en_d   = play_en;
        countdown_d = countdown;
        timer_d     = round_timer;
        p1_d        = p1_rounds;
        p2_d        = p2_rounds;
        winner_d    = round_winner;
        new_round_d = 1'b0;
        round_end   = 1'b0;
`ifdef GAME_PAUSE_EN
        pause_d     = pause_q;
`endif
        if ((state_q == S_COUNTDOWN || state_q == S_FIGHT) && frame_tick && !pause_q)
            frame_cnt_d = sec_tick ? '0 : frame_cnt_q + FW'(1);

        case (state_q)
            S_IDLE: begin
                if (fire_rise) begin
                    p1_d        = '0;
                    p2_d        = '0;
                    winner_d    = '0;
                    countdown_d = 2'(COUNTDOWN_SECS);
                    frame_cnt_d = '0;
                    new_round_d = 1'b1;
                    state_d     = S_COUNTDOWN;
                end
            end
            S_COUNTDOWN: begin
                if (sec_tick) begin
                    if (countdown == 2'd1) begin
                        countdown_d = '0;
                        timer_d     = 7'(ROUND_TIME);
                        play_en_d   = 1'b1;
                        frame_cnt_d = '0;
                        state_d     = S_FIGHT;
                    end else begin
                        countdown_d = countdown - 2'd1;
                    end
                end
            end
            S_FIGHT: begin
                if (!pause_q) begin
                    round_end = 1'b1;
                    if (hit_p1 && hit_p2) begin
                        winner_d = 2'd3;
                    end else if (hit_p1) begin
                        winner_d = 2'd1;
                        if (p1_rounds < 2'(WIN_ROUNDS)) p1_d = p1_rounds + 2'd1;
                    end else if (hit_p2) begin
                        winner_d = 2'd2;
                        if (p2_rounds < 2'(WIN_ROUNDS)) p2_d = p2_rounds + 2'd1;
                    end else if (sec_tick && round_timer == 7'd1) begin
                        timer_d  = '0;
                        winner_d = 2'd3;
                    end else begin
                        round_end = 1'b0;
                        if (sec_tick) timer_d = round_timer - 7'd1;
`ifdef GAME_PAUSE_EN
                        if (fire_rise) begin
                            pause_d   = 1'b1;
                            play_en_d = 1'b0;
                        end
`endif
                    end
                    if (round_end) begin
                        play_en_d  = 1'b0;
                        over_cnt_d = '0;
                        state_d    = S_ROUND_OVER;
                    end
                end
`ifdef GAME_PAUSE_EN
                else if (fire_rise) begin
                    pause_d   = 1'b0;
                    play_en_d = 1'b1;
                end
`endif
            end
            S_ROUND_OVER: begin
                if (frame_tick) begin
                    over_cnt_d = over_cnt_q + 8'd1;
                    if (over_cnt_q == 8'(OVER_FRAMES - 1)) begin
                        if (p1_rounds == 2'(WIN_ROUNDS) || p2_rounds == 2'(WIN_ROUNDS)) begin
                            state_d = S_MATCH_OVER;
                        end else begin
                            winner_d    = '0;
                            countdown_d = 2'(COUNTDOWN_SECS);
                            frame_cnt_d = '0;
                            new_round_d = 1'b1;
                            state_d     = S_COUNTDOWN;
                        end
                    end
                end
            end
            S_MATCH_OVER: begin
                if (fire_rise) begin
                    winner_d = '0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                play_en_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_pix or negedge sim_rst_n) begin
        if (!sim_rst_n) begin
            state_q      <= S_IDLE;
            frame_cnt_q  <= '0;
            over_cnt_q   <= '0;
            fire_q       <= 1'b0;
            armed_q      <= 1'b0;
            play_en      <= 1'b0;
            countdown    <= '0;
            round_timer  <= '0;
            p1_rounds    <= '0;
            p2_rounds    <= '0;
            round_winner <= '0;
            new_round    <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            over_cnt_q   <= over_cnt_d;
            fire_q       <= btn_fire;
            armed_q      <= 1'b1;
            play_en      <= play_en_d;
            countdown    <= countdown_d;
            round_timer  <= timer_d;
            p1_rounds    <= p1_d;
            p2_rounds    <= p2_d;
            round_winner <= winner_d;
            new_round    <= new_round_d;
        end
    end

`ifdef GAME_PAUSE_EN
    // pause only ever set inside FIGHT; every FIGHT exit goes through round_end
    always_ff @(posedge clk_pix or negedge sim_rst_n) begin
        if (!sim_rst_n) pause_q <= 1'b0;
        else            pause_q <= round_end ? 1'b0 : pause_d;
    end
`else
    assign pause_q = 1'b0;
`endif

endmodule

// File: tb/tb_game_round_ctrl.sv
// Testbench for game_round_ctrl: directed test-plan walk plus randomized run against a behavioural model.
module tb_game_round_ctrl;
    localparam int FPS = 60;
    localparam int CDS = 3;
    localparam int RT  = 60;
    localparam int WR  = 2;
    localparam int OF  = 120;
`ifdef GAME_PAUSE_EN
    localparam bit PAUSE = 1'b1;
`else
    localparam bit PAUSE = 1'b0;
`endif

    logic       clk_pix = 1'b0;
    logic       sim_rst_n = 1'b0;
    logic       frame_tick = 1'b0, btn_fire = 1'b0, hit_p1 = 1'b0, hit_p2 = 1'b0;
    logic [2:0] game_state;
    logic       play_en, new_round, paused;
    logic [1:0] countdown, p1_rounds, p2_rounds, round_winner;
    logic [6:0] round_timer;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    game_round_ctrl #(.FRAMES_PER_SEC(FPS), .COUNTDOWN_SECS(CDS), .ROUND_TIME(RT),
                      .WIN_ROUNDS(WR), .OVER_FRAMES(OF)) dut (
        .clk_pix(clk_pix), .sim_rst_n(sim_rst_n), .frame_tick(frame_tick), .btn_fire(btn_fire),
        .hit_p1(hit_p1), .hit_p2(hit_p2), .game_state(game_state), .play_en(play_en),
        .countdown(countdown), .round_timer(round_timer), .p1_rounds(p1_rounds),
        .p2_rounds(p2_rounds), .round_winner(round_winner), .new_round(new_round), .paused(paused)
    );

    always #5 clk_pix = ~clk_pix;

    // Behavioural model: phase name as int, frames counted into the current second
    int  m_phase, m_cd, m_timer, m_p1, m_p2, m_win, m_frames, m_over;
    bit  m_play, m_new, m_pause, m_prev_btn, m_armed;

    task automatic model_reset();
        m_phase = 0; m_cd = 0; m_timer = 0; m_p1 = 0; m_p2 = 0; m_win = 0;
        m_frames = 0; m_over = 0; m_play = 0; m_new = 0; m_pause = 0;
        m_prev_btn = 0; m_armed = 0;
    endtask

    task automatic model_step();
        bit rise, sec, done;
        rise = m_armed && btn_fire && !m_prev_btn;
        m_prev_btn = btn_fire;
        m_armed = 1;
        m_new = 0;
        sec = 0;
        if ((m_phase == 1 || m_phase == 2) && frame_tick && !m_pause) begin
            m_frames = m_frames + 1;
            if (m_frames == FPS) begin
                m_frames = 0;
                sec = 1;
            end
        end
        case (m_phase)
            0: if (rise) begin
                m_p1 = 0; m_p2 = 0; m_win = 0; m_cd = CDS; m_frames = 0; m_new = 1; m_phase = 1;
            end
            1: if (sec) begin
                if (m_cd == 1) begin
                    m_cd = 0; m_timer = RT; m_play = 1; m_frames = 0; m_phase = 2;
                end else m_cd = m_cd - 1;
            end
            2: if (!m_pause) begin
                done = 1;
                if (hit_p1 && hit_p2) m_win = 3;
                else if (hit_p1) begin m_win = 1; m_p1 = (m_p1 < WR) ? m_p1 + 1 : m_p1; end
                else if (hit_p2) begin m_win = 2; m_p2 = (m_p2 < WR) ? m_p2 + 1 : m_p2; end
                else if (sec && m_timer == 1) begin m_timer = 0; m_win = 3; end
                else begin
                    done = 0;
                    if (sec) m_timer = m_timer - 1;
                    if (PAUSE && rise) begin m_pause = 1; m_play = 0; end
                end
                if (done) begin m_play = 0; m_over = 0; m_phase = 3; end
            end else if (rise) begin
                m_pause = 0; m_play = 1;
            end
            3: if (frame_tick) begin
                m_over = m_over + 1;
                if (m_over == OF) begin
                    if (m_p1 == WR || m_p2 == WR) m_phase = 4;
                    else begin m_win = 0; m_cd = CDS; m_frames = 0; m_new = 1; m_phase = 1; end
                end
            end
            4: if (rise) begin m_win = 0; m_phase = 0; end
            default: m_phase = 0;
        endcase
    endtask

    always @(posedge clk_pix or negedge sim_rst_n) begin
        if (!sim_rst_n) model_reset();
        else            model_step();
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk_pix) begin
        if (chk_en) begin
            check("game_state", int'(game_state), m_phase);
            check("play_en", int'(play_en), int'(m_play));
            check("countdown", int'(countdown), m_cd);
            check("round_timer", int'(round_timer), m_timer);
            check("p1_rounds", int'(p1_rounds), m_p1);
            check("p2_rounds", int'(p2_rounds), m_p2);
            check("round_winner", int'(round_winner), m_win);
            check("new_round", int'(new_round), int'(m_new));
            check("paused", int'(paused), int'(m_pause));
        end
    end

    task automatic frames(input int n);
        @(negedge clk_pix); frame_tick = 1'b1;
        repeat (n) @(negedge clk_pix);
        frame_tick = 1'b0;
    endtask

    task automatic press_fire();
        @(negedge clk_pix); btn_fire = 1'b1;
        @(negedge clk_pix); btn_fire = 1'b0;
    endtask

    task automatic pulse_hit(input bit a, input bit b);
        @(negedge clk_pix); hit_p1 = a; hit_p2 = b;
        @(negedge clk_pix); hit_p1 = 1'b0; hit_p2 = 1'b0;
    endtask

    initial begin
        sim_rst_n = 1'b0;
        repeat (3) @(negedge clk_pix);
        chk_en = 1'b1;
        check("lit_reset_state", int'(game_state), 0);
        check("lit_reset_timer", int'(round_timer), 0);
        sim_rst_n = 1'b1;
        repeat (3) @(negedge clk_pix);

        // Start match and run countdown into the first fight
        @(negedge clk_pix); btn_fire = 1'b1;
        @(negedge clk_pix);
        check("lit_start_state", int'(game_state), 1);
        check("lit_start_new_round", int'(new_round), 1);
        check("lit_start_countdown", int'(countdown), 3);
        btn_fire = 1'b0;
        @(negedge clk_pix);
        check("lit_new_round_width", int'(new_round), 0);
        frames(3 * FPS);
        check("lit_fight_state", int'(game_state), 2);
        check("lit_fight_play", int'(play_en), 1);
        check("lit_fight_timer", int'(round_timer), 60);

        pulse_hit(1, 0);
        check("lit_p1hit_state", int'(game_state), 3);
        check("lit_p1hit_winner", int'(round_winner), 1);
        check("lit_p1hit_score", int'(p1_rounds), 1);
        check("lit_p1hit_play", int'(play_en), 0);
        frames(OF);
        check("lit_over_state", int'(game_state), 1);
        check("lit_over_new_round", int'(new_round), 1);
        check("lit_over_winner", int'(round_winner), 0);

        // Double hit, then a timeout draw
        frames(3 * FPS);
        pulse_hit(1, 1);
        check("lit_dbl_winner", int'(round_winner), 3);
        check("lit_dbl_p1", int'(p1_rounds), 1);
        check("lit_dbl_p2", int'(p2_rounds), 0);
        frames(OF);
        frames(3 * FPS);
        frames(RT * FPS);
        check("lit_timeout_state", int'(game_state), 3);
        check("lit_timeout_timer", int'(round_timer), 0);
        check("lit_timeout_winner", int'(round_winner), 3);

        // Two P2 wins end the match
        frames(OF);
        frames(3 * FPS);
        pulse_hit(0, 1);
        frames(OF);
        frames(3 * FPS);
        pulse_hit(0, 1);
        check("lit_p2win_state", int'(game_state), 3);
        frames(OF);
        check("lit_match_state", int'(game_state), 4);
        check("lit_match_p2", int'(p2_rounds), 2);
        press_fire();
        check("lit_idle_state", int'(game_state), 0);
        check("lit_idle_p2_hold", int'(p2_rounds), 2);

        // New match into FIGHT, optional pause, then async reset
        press_fire();
        check("lit_rematch_p2", int'(p2_rounds), 0);
        frames(3 * FPS);
        check("lit_fight2_state", int'(game_state), 2);
`ifdef GAME_PAUSE_EN
        press_fire();
        check("lit_pause_on", int'(paused), 1);
        check("lit_pause_play", int'(play_en), 0);
        frames(200);
        pulse_hit(1, 0);
        check("lit_pause_timer", int'(round_timer), 60);
        check("lit_pause_p1", int'(p1_rounds), 0);
        check("lit_pause_state", int'(game_state), 2);
        press_fire();
        check("lit_pause_off", int'(paused), 0);
        check("lit_pause_play_back", int'(play_en), 1);
`else
        press_fire();
        check("lit_nopause_paused", int'(paused), 0);
        check("lit_nopause_play", int'(play_en), 1);
`endif
        #2 sim_rst_n = 1'b0;
        #1;
        check("lit_arst_state", int'(game_state), 0);
        check("lit_arst_play", int'(play_en), 0);
        check("lit_arst_timer", int'(round_timer), 0);
        @(negedge clk_pix); btn_fire = 1'b1;
        @(negedge clk_pix); sim_rst_n = 1'b1;
        repeat (5) @(negedge clk_pix);
        check("lit_held_btn_idle", int'(game_state), 0);
        btn_fire = 1'b0;

        // Randomized run
        for (int i = 0; i < 40000; i++) begin
            @(negedge clk_pix);
            frame_tick = ($urandom_range(2) == 0);
            if ($urandom_range(39) == 0) btn_fire = ~btn_fire;
            hit_p1 = ($urandom_range(399) == 0);
            hit_p2 = ($urandom_range(399) == 0);
            if ($urandom_range(14999) == 0) begin
                sim_rst_n = 1'b0;
                @(negedge clk_pix);
                sim_rst_n = 1'b1;
            end
        end
        @(negedge clk_pix);
        frame_tick = 1'b0; hit_p1 = 1'b0; hit_p2 = 1'b0;
        @(negedge clk_pix);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
